// File: rtl/rf_bypass_multi.sv
// rf_bypass_multi: parametrised register file with two prioritised write
// ports (B over A), combinational reads with same-cycle write bypass on
// every read port, optional hardwired-zero register 0, a write-collision
// flag and a sticky copy of that flag.
module rf_bypass_multi #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 3,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREAD*ADDR_W-1:0]   readRegSel,
  output logic [NREAD*WIDTH-1:0]    readData,
  input  logic [ADDR_W-1:0]         writeRegSelA,
  input  logic [WIDTH-1:0]          writeDataA,
  input  logic                      writeEnA,
  input  logic [ADDR_W-1:0]         writeRegSelB,
  input  logic [WIDTH-1:0]          writeDataB,
  input  logic                      writeEnB,
  output logic                      err,
  output logic                      errSticky
);

  localparam int   DEPTH  = 1 << ADDR_W;
  localparam logic ZERO_EN = (ZERO_REG != 0);

  logic [WIDTH-1:0] regFile [DEPTH];
  logic             errStickyReg;

  // Writes into register 0 are dropped when it is hardwired to zero.
  logic writeOkA;
  logic writeOkB;
  assign writeOkA = writeEnA && !(ZERO_EN && (writeRegSelA == '0));
  assign writeOkB = writeEnB && !(ZERO_EN && (writeRegSelB == '0));

  // Collision flag is diagnostic only; masked while in reset.
  assign err = !rst && writeEnA && writeEnB && (writeRegSelA == writeRegSelB);

  // Storage update: A first, then B, so B overrides A on a shared address.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regFile[i] <= '0;
      end
    end else begin
      if (writeOkA) begin
        regFile[writeRegSelA] <= writeDataA;
      end
      if (writeOkB) begin
        regFile[writeRegSelB] <= writeDataB;
      end
    end
  end

  // Sticky error accumulates collisions until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      errStickyReg <= 1'b0;
    end else begin
      errStickyReg <= errStickyReg | err;
    end
  end

  assign errSticky = errStickyReg;

  genvar gi;
  generate
    for (gi = 0; gi < NREAD; gi++) begin : g_read
      logic [ADDR_W-1:0] portSel;
      logic [WIDTH-1:0]  readVal;

      assign portSel = readRegSel[gi*ADDR_W +: ADDR_W];

      // Read mux: bypass order mirrors write priority so the value seen
      // now equals what the register will hold after the edge.
      always_comb begin
        readVal = regFile[portSel];
        if (rst) begin
          readVal = '0;
        end else if (ZERO_EN && (portSel == '0)) begin
          readVal = '0;
        end else if (writeEnB && (writeRegSelB == portSel)) begin
          readVal = writeDataB;
        end else if (writeEnA && (writeRegSelA == portSel)) begin
          readVal = writeDataA;
        end
      end

      assign readData[gi*WIDTH +: WIDTH] = readVal;
    end
  endgenerate

endmodule

// File: tb/tb_rf_bypass_multi.sv
// Bench for rf_bypass_multi: default build, a ZERO_REG=1 build sharing the
// default build's inputs, and a 4-port 32-bit build. Expected values go into
// a scoreboard queue as stimulus is driven and are popped at the falling edge.
module tb_rf_bypass_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Default build and ZERO_REG build share these inputs.
  logic [5:0]  readRegSel;
  logic [2:0]  selA, selB;
  logic [15:0] dataA, dataB;
  logic        enA, enB;
  logic [31:0] readData;
  logic        err, errSticky;
  logic [31:0] readDataZ;
  logic        errZ, errStickyZ;

  // Wide build inputs.
  logic [11:0]  readRegSelW;
  logic [2:0]   selAW, selBW;
  logic [31:0]  dataAW, dataBW;
  logic         enAW, enBW;
  logic [127:0] readDataW;
  logic         errW, errStickyW;

  rf_bypass_multi #(.WIDTH(16), .ADDR_W(3), .NREAD(2), .ZERO_REG(0)) dut (
    .clk(clk), .rst(rst), .readRegSel(readRegSel), .readData(readData),
    .writeRegSelA(selA), .writeDataA(dataA), .writeEnA(enA),
    .writeRegSelB(selB), .writeDataB(dataB), .writeEnB(enB),
    .err(err), .errSticky(errSticky)
  );

  rf_bypass_multi #(.WIDTH(16), .ADDR_W(3), .NREAD(2), .ZERO_REG(1)) dutZ (
    .clk(clk), .rst(rst), .readRegSel(readRegSel), .readData(readDataZ),
    .writeRegSelA(selA), .writeDataA(dataA), .writeEnA(enA),
    .writeRegSelB(selB), .writeDataB(dataB), .writeEnB(enB),
    .err(errZ), .errSticky(errStickyZ)
  );

  rf_bypass_multi #(.WIDTH(32), .ADDR_W(3), .NREAD(4), .ZERO_REG(0)) dutW (
    .clk(clk), .rst(rst), .readRegSel(readRegSelW), .readData(readDataW),
    .writeRegSelA(selAW), .writeDataA(dataAW), .writeEnA(enAW),
    .writeRegSelB(selBW), .writeDataB(dataBW), .writeEnB(enBW),
    .err(errW), .errSticky(errStickyW)
  );

  typedef struct {
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sbQ[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Signal ids for the scoreboard.
  localparam int S_RD0 = 0, S_RD1 = 1, S_ERR = 2, S_STK = 3;
  localparam int S_Z0 = 4, S_Z1 = 5, S_W0 = 6;
  localparam int S_WSTK = 10, S_ZERR = 11, S_ZSTK = 12, S_WERR = 13;

  function automatic logic [31:0] observe(int sig);
    case (sig)
      S_RD0:  return {16'h0, readData[15:0]};
      S_RD1:  return {16'h0, readData[31:16]};
      S_ERR:  return {31'h0, err};
      S_STK:  return {31'h0, errSticky};
      S_Z0:   return {16'h0, readDataZ[15:0]};
      S_Z1:   return {16'h0, readDataZ[31:16]};
      6:      return readDataW[31:0];
      7:      return readDataW[63:32];
      8:      return readDataW[95:64];
      9:      return readDataW[127:96];
      S_WSTK: return {31'h0, errStickyW};
      S_ZERR: return {31'h0, errZ};
      S_ZSTK: return {31'h0, errStickyZ};
      S_WERR: return {31'h0, errW};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input int sig, input logic [31:0] val, input string name);
    exp_t e;
    e.sig = sig;
    e.val = val;
    e.name = name;
    sbQ.push_back(e);
  endtask

  task automatic idle();
    rst = 1'b0;
    enA = 1'b0; enB = 1'b0; selA = '0; selB = '0; dataA = '0; dataB = '0;
    enAW = 1'b0; enBW = 1'b0; selAW = '0; selBW = '0; dataAW = '0; dataBW = '0;
    readRegSel = '0;
    readRegSelW = '0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 9; c++) begin
      idle();
      if (c == 0) begin
        rst = 1'b1;
        enA = 1'b1; enB = 1'b1; selA = 3'd3; selB = 3'd3;
        dataA = 16'h5555; dataB = 16'h6666;
        enAW = 1'b1; enBW = 1'b1; selAW = 3'd3; selBW = 3'd3;
        dataAW = 32'h5555_5555; dataBW = 32'h6666_6666;
        readRegSel = {3'd3, 3'd3};
        readRegSelW = {3'd3, 3'd3, 3'd3, 3'd3};
        push(S_ERR, 32'h0, "rst_err");
        push(S_WERR, 32'h0, "rst_err_w");
      end else begin
        readRegSel = {3'(7 - (c - 1)), 3'(c - 1)};
        readRegSelW = {4{3'(c - 1)}};
        push(S_STK, 32'h0, "rst_stk");
        push(S_WSTK, 32'h0, "rst_stk_w");
        push(S_ZSTK, 32'h0, "rst_stk_z");
      end
      push(S_RD0, 32'h0, "rst_rd0");
      push(S_RD1, 32'h0, "rst_rd1");
      push(S_Z0, 32'h0, "rst_z0");
      for (int p = 0; p < 4; p++) push(S_W0 + p, 32'h0, "rst_w");
      $display("tx reset c=%0d rst=%0b sel=%h", c, rst, readRegSel);
      @(negedge clk);
      while (sbQ.size() > 0) begin
        exp_t e;
        logic [31:0] got;
        e = sbQ.pop_front();
        got = observe(e.sig);
        vectors++;
        if (got !== e.val) begin
          miscompares++;
          $display("FAIL %s c=%0d got=%h exp=%h", e.name, c, got, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_write_readback();
    for (int c = 0; c < 3; c++) begin
      idle();
      case (c)
        0: begin
          enA = 1'b1; selA = 3'd3; dataA = 16'h1234;
          readRegSel = {3'd0, 3'd3};
          push(S_RD0, 32'h1234, "wr_bypass_a");
          push(S_RD1, 32'h0000, "wr_r0");
        end
        1: begin
          enB = 1'b1; selB = 3'd5; dataB = 16'hBEEF;
          readRegSel = {3'd5, 3'd3};
          push(S_RD0, 32'h1234, "wr_r3");
          push(S_RD1, 32'hBEEF, "wr_bypass_b");
        end
        default: begin
          readRegSel = {3'd5, 3'd3};
          push(S_RD0, 32'h1234, "rb_r3");
          push(S_RD1, 32'hBEEF, "rb_r5");
          push(S_ERR, 32'h0, "rb_err");
        end
      endcase
      $display("tx write_readback c=%0d", c);
      @(negedge clk);
      while (sbQ.size() > 0) begin
        exp_t e;
        logic [31:0] got;
        e = sbQ.pop_front();
        got = observe(e.sig);
        vectors++;
        if (got !== e.val) begin
          miscompares++;
          $display("FAIL %s c=%0d got=%h exp=%h", e.name, c, got, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_priority();
    for (int c = 0; c < 3; c++) begin
      idle();
      readRegSel = {3'd2, 3'd2};
      case (c)
        0: begin
          enA = 1'b1; selA = 3'd2; dataA = 16'h1111;
          push(S_ERR, 32'h0, "pri_setup_err");
        end
        1: begin
          enA = 1'b1; selA = 3'd2; dataA = 16'h2222;
          enB = 1'b1; selB = 3'd2; dataB = 16'h3333;
          push(S_RD0, 32'h3333, "pri_rd0");
          push(S_RD1, 32'h3333, "pri_rd1");
          push(S_ERR, 32'h1, "pri_err");
          push(S_STK, 32'h0, "pri_stk_before");
        end
        default: begin
          push(S_RD0, 32'h3333, "pri_stored");
          push(S_ERR, 32'h0, "pri_err_clear");
          push(S_STK, 32'h1, "pri_stk_set");
        end
      endcase
      $display("tx priority c=%0d", c);
      @(negedge clk);
      while (sbQ.size() > 0) begin
        exp_t e;
        logic [31:0] got;
        e = sbQ.pop_front();
        got = observe(e.sig);
        vectors++;
        if (got !== e.val) begin
          miscompares++;
          $display("FAIL %s c=%0d got=%h exp=%h", e.name, c, got, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bypass_a();
    for (int c = 0; c < 3; c++) begin
      idle();
      case (c)
        0: begin
          enB = 1'b1; selB = 3'd6; dataB = 16'h6666;
        end
        1: begin
          enA = 1'b1; selA = 3'd7; dataA = 16'hA5A5;
          readRegSel = {3'd7, 3'd6};
          push(S_RD0, 32'h6666, "bpa_old_r6");
          push(S_RD1, 32'hA5A5, "bpa_bypass");
          push(S_STK, 32'h1, "bpa_stk_hold");
        end
        default: begin
          readRegSel = {3'd7, 3'd7};
          push(S_RD0, 32'hA5A5, "bpa_same0");
          push(S_RD1, 32'hA5A5, "bpa_same1");
        end
      endcase
      $display("tx bypass_a c=%0d", c);
      @(negedge clk);
      while (sbQ.size() > 0) begin
        exp_t e;
        logic [31:0] got;
        e = sbQ.pop_front();
        got = observe(e.sig);
        vectors++;
        if (got !== e.val) begin
          miscompares++;
          $display("FAIL %s c=%0d got=%h exp=%h", e.name, c, got, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_reg();
    for (int c = 0; c < 4; c++) begin
      idle();
      case (c)
        0: begin
          enA = 1'b1; selA = 3'd0; dataA = 16'hFFFF;
          readRegSel = {3'd0, 3'd0};
          push(S_RD0, 32'hFFFF, "zr_off_bypass");
          push(S_Z0, 32'h0, "zr_on_bypass0");
          push(S_Z1, 32'h0, "zr_on_bypass1");
        end
        1: begin
          readRegSel = {3'd3, 3'd0};
          push(S_RD0, 32'hFFFF, "zr_off_stored");
          push(S_RD1, 32'h1234, "zr_off_r3");
          push(S_Z0, 32'h0, "zr_on_stored");
          push(S_Z1, 32'h1234, "zr_on_r3");
        end
        2: begin
          enA = 1'b1; selA = 3'd0; dataA = 16'h0001;
          enB = 1'b1; selB = 3'd0; dataB = 16'h0002;
          readRegSel = {3'd0, 3'd0};
          push(S_RD0, 32'h0002, "zr_off_coll");
          push(S_Z0, 32'h0, "zr_on_coll_rd");
          push(S_ZERR, 32'h1, "zr_on_coll_err");
        end
        default: begin
          readRegSel = {3'd0, 3'd0};
          push(S_RD1, 32'h0002, "zr_off_after");
          push(S_Z1, 32'h0, "zr_on_after");
          push(S_ZSTK, 32'h1, "zr_on_stk");
        end
      endcase
      $display("tx zero_reg c=%0d", c);
      @(negedge clk);
      while (sbQ.size() > 0) begin
        exp_t e;
        logic [31:0] got;
        e = sbQ.pop_front();
        got = observe(e.sig);
        vectors++;
        if (got !== e.val) begin
          miscompares++;
          $display("FAIL %s c=%0d got=%h exp=%h", e.name, c, got, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // Randomised traffic on the default build against a small behavioural model.
  task automatic test_random();
    logic [15:0] mdl [8];
    logic        mdlStk;
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0;
    mdlStk = 1'b0;
    for (int c = 0; c < 60; c++) begin
      logic [15:0] expRd;
      logic        expErr;
      idle();
      enA = 1'($urandom_range(0, 1)); selA = 3'($urandom_range(0, 7));
      enB = 1'($urandom_range(0, 1)); selB = 3'($urandom_range(0, 7));
      dataA = 16'($urandom); dataB = 16'($urandom);
      readRegSel = 6'($urandom_range(0, 63));
      for (int p = 0; p < 2; p++) begin
        logic [2:0] s;
        s = readRegSel[p*3 +: 3];
        if (enB && selB == s) expRd = dataB;
        else if (enA && selA == s) expRd = dataA;
        else expRd = mdl[s];
        push(S_RD0 + p, {16'h0, expRd}, "rnd_rd");
      end
      expErr = enA && enB && (selA == selB);
      push(S_ERR, {31'h0, expErr}, "rnd_err");
      push(S_STK, {31'h0, mdlStk}, "rnd_stk");
      $display("tx random c=%0d A=%0b:%0d:%h B=%0b:%0d:%h sel=%h",
               c, enA, selA, dataA, enB, selB, dataB, readRegSel);
      @(negedge clk);
      while (sbQ.size() > 0) begin
        exp_t e;
        logic [31:0] got;
        e = sbQ.pop_front();
        got = observe(e.sig);
        vectors++;
        if (got !== e.val) begin
          miscompares++;
          $display("FAIL %s c=%0d got=%h exp=%h", e.name, c, got, e.val);
        end
      end
      if (enA) mdl[selA] = dataA;
      if (enB) mdl[selB] = dataB;
      mdlStk = mdlStk | expErr;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      idle();
      case (c)
        0: begin
          enA = 1'b1; selA = 3'd4; dataA = 16'h0011;
          enB = 1'b1; selB = 3'd4; dataB = 16'h00FF;
          readRegSel = {3'd4, 3'd4};
          enAW = 1'b1; selAW = 3'd4; dataAW = 32'h1234_5678;
          enBW = 1'b1; selBW = 3'd4; dataBW = 32'hDEAD_00FF;
          readRegSelW = {3'd4, 3'd4, 3'd1, 3'd4};
          push(S_RD0, 32'h00FF, "mid_pre_rd0");
          push(S_W0 + 0, 32'hDEAD_00FF, "mid_pre_w0");
          push(S_W0 + 1, 32'h0, "mid_pre_w1");
          push(S_W0 + 2, 32'hDEAD_00FF, "mid_pre_w2");
          push(S_W0 + 3, 32'hDEAD_00FF, "mid_pre_w3");
          push(S_WERR, 32'h1, "mid_pre_werr");
        end
        1: begin
          rst = 1'b1;
          enA = 1'b1; selA = 3'd4; dataA = 16'h1111;
          enB = 1'b1; selB = 3'd4; dataB = 16'h7777;
          readRegSel = {3'd4, 3'd4};
          enAW = 1'b1; selAW = 3'd4; dataAW = 32'h1111_1111;
          enBW = 1'b1; selBW = 3'd4; dataBW = 32'h7777_7777;
          readRegSelW = {3'd0, 3'd4, 3'd1, 3'd4};
          push(S_RD0, 32'h0, "mid_rst_rd0");
          push(S_RD1, 32'h0, "mid_rst_rd1");
          push(S_ERR, 32'h0, "mid_rst_err");
          push(S_STK, 32'h1, "mid_rst_stk_held");
          for (int p = 0; p < 4; p++) push(S_W0 + p, 32'h0, "mid_rst_w");
          push(S_WERR, 32'h0, "mid_rst_werr");
          push(S_WSTK, 32'h1, "mid_rst_wstk_held");
        end
        default: begin
          readRegSel = {3'd4, 3'd4};
          readRegSelW = {3'd4, 3'd4, 3'd4, 3'd4};
          push(S_RD0, 32'h0, "mid_post_rd0");
          push(S_RD1, 32'h0, "mid_post_rd1");
          push(S_STK, 32'h0, "mid_post_stk");
          for (int p = 0; p < 4; p++) push(S_W0 + p, 32'h0, "mid_post_w");
          push(S_WSTK, 32'h0, "mid_post_wstk");
        end
      endcase
      $display("tx reset_mid c=%0d rst=%0b", c, rst);
      @(negedge clk);
      while (sbQ.size() > 0) begin
        exp_t e;
        logic [31:0] got;
        e = sbQ.pop_front();
        got = observe(e.sig);
        vectors++;
        if (got !== e.val) begin
          miscompares++;
          $display("FAIL %s c=%0d got=%h exp=%h", e.name, c, got, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    @(posedge clk); #1;
    test_reset();
    test_write_readback();
    test_priority();
    test_bypass_a();
    test_zero_reg();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
